// File: rtl/acq_gate_ctrl.sv
// rtl/acq_gate_ctrl.sv - multi-channel acquisition gate with timed run, elapsed and event counters
module acq_gate_ctrl #(
  parameter int NCH = 2,
  parameter int DW  = 8,
  parameter int TW  = 32,
  parameter int CW  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              clr,
  input  logic              mode_timed,
  input  logic [TW-1:0]     run_len,
  input  logic [NCH*DW-1:0] din,
  input  logic [NCH-1:0]    sin,
  output logic [NCH*DW-1:0] dout,
  output logic [NCH-1:0]    sout,
  output logic              clr_out,
  output logic              running,
  output logic              done,
  output logic [TW-1:0]     elapsed,
  output logic [NCH*CW-1:0] ev_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          gate;
  logic [TW:0]   el_inc;
  logic [TW-1:0] el_nxt;
  logic          expire;
  logic [CW-1:0] cnt [NCH];

  assign gate    = (state == ST_RUN);
  assign running = gate;
  assign done    = (state == ST_DONE);
  assign dout    = din;
  assign sout    = sin & {NCH{gate}};

  // One extra bit so elapsed+1 never wraps when compared against run_len.
  assign el_inc = {1'b0, elapsed} + {{TW{1'b0}}, 1'b1};
  assign el_nxt = (&elapsed) ? elapsed : el_inc[TW-1:0];

  // A zero run_len means the timed run never ends on its own.
  assign expire = mode_timed && (run_len != '0) && (el_inc >= {1'b0, run_len});

  // Next-state selection: clr beats stop beats start; expiry only acts from RUN.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ST_RUN;
    end else if (stop) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_nxt = ST_RUN;
        ST_RUN:  if (expire) state_nxt = ST_DONE;
        ST_DONE: if (start && !expire) state_nxt = ST_RUN;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register and the one-cycle clear pulse towards the correlator core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      clr_out <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_out <= clr;
    end
  end

  // Elapsed gated-cycle counter, saturating; zeroed by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elapsed <= '0;
    end else if (clr) begin
      elapsed <= '0;
    end else if (gate) begin
      elapsed <= el_nxt;
    end
  end

  // Per-channel saturating event counters; only gated strobes are counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) cnt[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < NCH; k++) cnt[k] <= '0;
    end else if (gate) begin
      for (int k = 0; k < NCH; k++) begin
        if (sin[k] && !(&cnt[k])) cnt[k] <= cnt[k] + CW'(1);
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_pack
      assign ev_cnt[g*CW +: CW] = cnt[g];
    end
  endgenerate

endmodule
